bridge_fanout: RTL and testbench
================================

Name: bridge_fanout

Overview:
- Generalised bridge router: one host-side bridge port drives N_LEAVES leaf bridge ports, selected by parametrised address base/mask decode.
- Forwarding to leaves is registered. Read data returns through a pipelined, latency-matched mux and is held stable on the host side.
- Sits between the top-level bridge and per-core register/memory blocks. Replaces hand-wired per-leaf connection and read-mux logic.

Parameters:
- N_LEAVES, 4, number of leaf ports (1..16).
- DATA_WIDTH, 32, bridge data width.
- LEAF_BASE, {N_LEAVES{32'h0}}, packed N_LEAVES*32 base addresses; leaf i occupies bits [32*i+:32].
- LEAF_MASK, {N_LEAVES{32'hFF00_0000}}, packed per-leaf compare masks. Hit when (addr & mask) == (base & mask).
- LEAF_RD_LATENCY, 1, cycles from leaf rd (registered) to valid leaf rd_data (0..7).
- DEFAULT_RDATA, 32'hFFFF_FFFF, host read data for unmapped reads.

Ports:
- clk  in  1  bridge clock.
- reset  in  1  asynchronous, active-high reset.
- host_addr  in  32  bridge address (pocket::bridge_addr_t).
- host_wr_data  in  DATA_WIDTH  write data.
- host_wr  in  1  write strobe, one cycle per access.
- host_rd  in  1  read strobe, one cycle per access.
- host_rd_data  out  DATA_WIDTH  held read data.
- leaf_addr  out  N_LEAVES*32  per-leaf address.
- leaf_wr_data  out  N_LEAVES*DATA_WIDTH  per-leaf write data.
- leaf_wr  out  N_LEAVES  per-leaf write strobe.
- leaf_rd  out  N_LEAVES  per-leaf read strobe.
- leaf_rd_data  in  N_LEAVES*DATA_WIDTH  per-leaf read data.
- unmapped_err  out  1  sticky flag: an access hit no leaf.
- err_clear  in  1  clears unmapped_err.

Behaviour:
- Reset values:
  - all leaf_wr, leaf_rd = 0; leaf_addr, leaf_wr_data = 0.
  - host_rd_data = 0.
  - unmapped_err = 0.
  - read pipeline valid bits = 0.
- Decode (combinational):
  - hit[i] = ((host_addr & MASK[i]) == (BASE[i] & MASK[i])).
  - Several hits: the lowest index wins.
  - No hit: unmapped.
- Forward stage (cycle T+1 after strobe at T):
  - Every leaf_addr and leaf_wr_data gets the registered host_addr and host_wr_data. This is a broadcast; only the strobes are qualified.
  - leaf_wr[sel] and leaf_rd[sel] pulse for exactly one cycle. At most one bit is set.
- Write: leaf write pulse at T+1. No host-side response.
- Read pipeline:
  - Shift register of depth LEAF_RD_LATENCY+1, carrying {valid, mapped, sel index}.
  - Entry created at T.
  - At T+1+LEAF_RD_LATENCY the selected leaf_rd_data is sampled. Unmapped entries use DEFAULT_RDATA.
  - Result is registered into host_rd_data, visible at T+2+LEAF_RD_LATENCY.
- host_rd_data hold: the value persists until the next read completes. It is unaffected by writes and by leaf_rd_data changing.
- Back-to-back reads on consecutive cycles are fully pipelined. Each completes in order, one cycle apart, with no drops.
- Simultaneous host_wr and host_rd in one cycle:
  - the write proceeds;
  - the read is dropped, so no pipeline entry and no leaf_rd;
  - unmapped_err sets (protocol violation).
- Unmapped access, wr or rd: no leaf strobe; unmapped_err sets at T+1.
- err_clear:
  - clears unmapped_err next cycle;
  - a set event in the same cycle wins (flag stays 1).
- Reset mid-read: in-flight entries are discarded; host_rd_data returns to 0.
- Worst-case total host read latency is LEAF_RD_LATENCY+2. The top level must budget this against bridge timing.

Decomposition:
- pocket package additions:
  - bridge_fanout_max_leaves = 16 constant;
  - leaf_sel_t typedef, logic [3:0];
  - helper function bridge_addr_hit(addr, base, mask).
- One sub-module: bridge_fanout_rd_pipe. It holds the parametrised-depth valid/sel shift register plus the output data register, and is reused by future single-leaf latency adapters.
- A STATIC_ASSERT checks N_LEAVES <= 16 and LEAF_RD_LATENCY <= 7.

Test Plan:
- Config: N_LEAVES=4, bases 0x0000_0000/0x1000_0000/0x2000_0000/0x2000_0000, mask 0xF000_0000, LATENCY=2.
- Write 0x1000_0010 = 0xA5A5_0001 at cycle 0 -> cycle 1: leaf_wr = 4'b0010, leaf1 addr/data match, other strobes 0.
- Read 0x2000_0004 with leaf2 returning 0x1234_5678 -> cycle 1: leaf_rd = 4'b0100 (leaf 2 beats overlapping leaf 3); cycle 4: host_rd_data = 0x1234_5678, held through 10 idle cycles.
- Reads to leaf0, leaf1, leaf2 on cycles 0, 1, 2, with distinct data -> host_rd_data updates on cycles 4, 5, 6 in order, with the correct values.
- Read 0x3000_0000 -> no leaf_rd; host_rd_data = 0xFFFF_FFFF at cycle 4; unmapped_err = 1 from cycle 1. err_clear pulse -> 0 the next cycle. err_clear coincident with a new unmapped write -> stays 1.
- host_wr and host_rd together on 0x0000_0000 -> leaf_wr[0] pulses, no leaf_rd, host_rd_data unchanged, unmapped_err = 1.
- Assert reset at cycle 2 of an in-flight read -> all strobes 0 immediately, host_rd_data = 0, no late update after reset release.

Source files
------------

// File: rtl/bridge_fanout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fanout_pkg
// Description : Shared types, limits and the address-hit helper for the
//               bridge fan-out router.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_fanout_pkg;

    localparam int bridge_fanout_max_leaves = 16;
    localparam int c_max_rd_latency         = 7;

    typedef logic [31:0] bridge_addr_t;
    typedef logic [3:0]  leaf_sel_t;

    // One read-pipeline slot; mapped=0 means "answer with the default word".
    typedef struct packed {
        logic      valid;
        logic      mapped;
        leaf_sel_t sel;
    } rd_tag_t;

    function automatic logic bridge_addr_hit(
        input bridge_addr_t addr,
        input bridge_addr_t base,
        input bridge_addr_t mask
    );
        return (addr & mask) == (base & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_fanout_if.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fanout_if
// Description : Host-side and packed leaf-side bridge signals of the fan-out.
// Revision    : 1.0 - initial release
// ============================================================================
interface bridge_fanout_if #(
    parameter int N_LEAVES   = 4,
    parameter int DATA_WIDTH = 32
);
    import bridge_fanout_pkg::*;

    bridge_addr_t                   host_addr;
    logic [DATA_WIDTH-1:0]          host_wr_data;
    logic                           host_wr;
    logic                           host_rd;
    logic [DATA_WIDTH-1:0]          host_rd_data;

    logic [N_LEAVES*32-1:0]         leaf_addr;
    logic [N_LEAVES*DATA_WIDTH-1:0] leaf_wr_data;
    logic [N_LEAVES-1:0]            leaf_wr;
    logic [N_LEAVES-1:0]            leaf_rd;
    logic [N_LEAVES*DATA_WIDTH-1:0] leaf_rd_data;

    modport master (
        output host_addr, host_wr_data, host_wr, host_rd, leaf_rd_data,
        input  host_rd_data, leaf_addr, leaf_wr_data, leaf_wr, leaf_rd
    );

    modport slave (
        input  host_addr, host_wr_data, host_wr, host_rd, leaf_rd_data,
        output host_rd_data, leaf_addr, leaf_wr_data, leaf_wr, leaf_rd
    );

endinterface
`default_nettype wire

// File: rtl/bridge_fanout_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fanout_rd_pipe
// Description : Latency-matched read return: tag shift register plus held
//               output data register.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_fanout_rd_pipe
    import bridge_fanout_pkg::*;
#(
    parameter int                    N_LEAVES      = 4,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DEPTH         = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = '1
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire rd_tag_t                        tag_in,
    input  wire logic [N_LEAVES*DATA_WIDTH-1:0] leaf_rd_data,
    output logic [DATA_WIDTH-1:0]               rd_data
);

    rd_tag_t               r_stage [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] w_sel_data;

    always_comb begin
        w_sel_data = DEFAULT_RDATA;
        if (r_stage[DEPTH-1].mapped && (int'(r_stage[DEPTH-1].sel) < N_LEAVES)) begin
            w_sel_data = leaf_rd_data[DATA_WIDTH*r_stage[DEPTH-1].sel +: DATA_WIDTH];
        end
    end

    // The last stage lines up with the cycle the leaf presents its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            r_stage[0] <= tag_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            if (r_stage[DEPTH-1].valid) begin
                r_rd_data <= w_sel_data;
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/bridge_fanout.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fanout
// Description : Routes one host bridge port to N_LEAVES leaf ports by
//               base/mask decode with a latency-matched read return.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_fanout
    import bridge_fanout_pkg::*;
#(
    parameter int                     N_LEAVES        = 4,
    parameter int                     DATA_WIDTH      = 32,
    parameter logic [N_LEAVES*32-1:0] LEAF_BASE       = {N_LEAVES{32'h0}},
    parameter logic [N_LEAVES*32-1:0] LEAF_MASK       = {N_LEAVES{32'hFF00_0000}},
    parameter int                     LEAF_RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0]  DEFAULT_RDATA   = DATA_WIDTH'(32'hFFFF_FFFF)
) (
    input  wire logic      clk,
    input  wire logic      reset,
    bridge_fanout_if.slave bus,
    output logic           unmapped_err,
    input  wire logic      err_clear
);

    localparam int c_pipe_depth = LEAF_RD_LATENCY + 1;

    if ((N_LEAVES < 1) || (N_LEAVES > bridge_fanout_max_leaves) ||
        (LEAF_RD_LATENCY < 0) || (LEAF_RD_LATENCY > c_max_rd_latency)) begin : g_param_check
        $error("bridge_fanout: N_LEAVES must be 1..16 and LEAF_RD_LATENCY 0..7");
    end

    logic                  w_hit;
    leaf_sel_t             w_sel;
    logic [N_LEAVES-1:0]   w_onehot;
    logic                  w_wr_go;
    logic                  w_rd_go;
    logic                  w_err_set;
    rd_tag_t               w_rd_tag;

    bridge_addr_t          r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [N_LEAVES-1:0]   r_leaf_wr;
    logic [N_LEAVES-1:0]   r_leaf_rd;
    logic                  r_unmapped_err;

    // Scan from the top so the lowest matching index is the last to win.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = N_LEAVES - 1; i >= 0; i--) begin
            if (bridge_addr_hit(bus.host_addr, LEAF_BASE[32*i +: 32], LEAF_MASK[32*i +: 32])) begin
                w_hit = 1'b1;
                w_sel = leaf_sel_t'(i);
            end
        end
    end

    assign w_onehot  = N_LEAVES'(1) << w_sel;
    assign w_wr_go   = bus.host_wr && w_hit;
    // A read colliding with a write is dropped and flagged.
    assign w_rd_go   = bus.host_rd && !bus.host_wr && w_hit;
    assign w_err_set = ((bus.host_wr || bus.host_rd) && !w_hit) || (bus.host_wr && bus.host_rd);

    assign w_rd_tag.valid  = bus.host_rd && !bus.host_wr;
    assign w_rd_tag.mapped = w_hit;
    assign w_rd_tag.sel    = w_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr         <= '0;
            r_wr_data      <= '0;
            r_leaf_wr      <= '0;
            r_leaf_rd      <= '0;
            r_unmapped_err <= 1'b0;
        end else begin
            r_addr    <= bus.host_addr;
            r_wr_data <= bus.host_wr_data;
            r_leaf_wr <= w_wr_go ? w_onehot : '0;
            r_leaf_rd <= w_rd_go ? w_onehot : '0;
            if (w_err_set) begin
                r_unmapped_err <= 1'b1;
            end else if (err_clear) begin
                r_unmapped_err <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_LEAVES; g++) begin : g_leaf_bcast
        assign bus.leaf_addr[32*g +: 32]                 = r_addr;
        assign bus.leaf_wr_data[DATA_WIDTH*g +: DATA_WIDTH] = r_wr_data;
    end

    assign bus.leaf_wr   = r_leaf_wr;
    assign bus.leaf_rd   = r_leaf_rd;
    assign unmapped_err  = r_unmapped_err;

    bridge_fanout_rd_pipe #(
        .N_LEAVES      (N_LEAVES),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (c_pipe_depth),
        .DEFAULT_RDATA (DEFAULT_RDATA)
    ) u_rd_pipe (
        .clk          (clk),
        .reset        (reset),
        .tag_in       (w_rd_tag),
        .leaf_rd_data (bus.leaf_rd_data),
        .rd_data      (bus.host_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_bridge_fanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_fanout
// Description : Directed scoreboard bench for bridge_fanout (4 leaves, latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_fanout;

    localparam int          c_n   = 4;
    localparam int          c_dw  = 32;
    localparam int          c_lat = 2;
    localparam logic [31:0] c_def = 32'hFFFF_FFFF;

    logic clk;
    logic reset;
    logic err_clear;
    logic unmapped_err;

    bridge_fanout_if #(.N_LEAVES(c_n), .DATA_WIDTH(c_dw)) bus ();

    bridge_fanout #(
        .N_LEAVES        (c_n),
        .DATA_WIDTH      (c_dw),
        .LEAF_BASE       ({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .LEAF_MASK       ({4{32'hF000_0000}}),
        .LEAF_RD_LATENCY (c_lat),
        .DEFAULT_RDATA   (c_def)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .unmapped_err (unmapped_err),
        .err_clear    (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          n_cmp;
    int          n_bad;
    logic        mon_en;
    logic [31:0] exp_hold;
    logic        exp_err;
    logic [31:0] leaf_val [c_n];
    logic [1:0]  hist [c_n];

    // Leaf model: data is valid only in the cycle c_lat after leaf_rd.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < c_n; i++) begin
            if (reset) hist[i] <= '0;
            else       hist[i] <= {hist[i][0], bus.leaf_rd[i]};
        end
    end

    always_comb begin
        bus.leaf_rd_data = '0;
        for (int i = 0; i < c_n; i++) begin
            bus.leaf_rd_data[32*i +: 32] = hist[i][c_lat-1] ? leaf_val[i] : (32'hBAD0_0000 | 32'(i));
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_hold = sb[0].val;
                void'(sb.pop_front());
            end
            chk("host_rd_data", bus.host_rd_data, exp_hold);
        end
    end

    function automatic int exp_sel(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return 0;
            4'h1:    return 1;
            4'h2:    return 2;
            default: return -1;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic access(input logic wr, input logic rd, input logic clr,
                          input logic [31:0] addr, input logic [31:0] data, input string tag);
        int         s;
        logic [3:0] exp_wr;
        logic [3:0] exp_rd;
        s      = exp_sel(addr);
        exp_wr = '0;
        exp_rd = '0;
        if (wr && s >= 0)        exp_wr[s] = 1'b1;
        if (rd && !wr && s >= 0) exp_rd[s] = 1'b1;
        bus.host_addr    = addr;
        bus.host_wr_data = data;
        bus.host_wr      = wr;
        bus.host_rd      = rd;
        err_clear        = clr;
        if (rd && !wr) sb.push_back('{val: (s < 0) ? c_def : leaf_val[s], due: cyc + 2 + c_lat});
        if (((wr || rd) && s < 0) || (wr && rd)) exp_err = 1'b1;
        else if (clr)                            exp_err = 1'b0;
        tick(1);
        bus.host_wr = 1'b0;
        bus.host_rd = 1'b0;
        err_clear   = 1'b0;
        chk({tag, " leaf_wr"}, 128'(bus.leaf_wr), 128'(exp_wr));
        chk({tag, " leaf_rd"}, 128'(bus.leaf_rd), 128'(exp_rd));
        chk({tag, " unmapped_err"}, 128'(unmapped_err), 128'(exp_err));
        if (s >= 0) begin
            chk({tag, " leaf_addr"}, 128'(bus.leaf_addr[32*s +: 32]), 128'(addr));
            chk({tag, " leaf_wr_data"}, 128'(bus.leaf_wr_data[32*s +: 32]), 128'(data));
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        mon_en = 1'b0; exp_hold = '0; exp_err = 1'b0;
        leaf_val[0] = 32'h1111_0000; leaf_val[1] = 32'h2222_0001;
        leaf_val[2] = 32'h1234_5678; leaf_val[3] = 32'h4444_0003;
        bus.host_addr = '0; bus.host_wr_data = '0; bus.host_wr = 1'b0; bus.host_rd = 1'b0;
        err_clear = 1'b0;
        reset = 1'b1;
        tick(3);
        chk("reset leaf_wr", 128'(bus.leaf_wr), 128'(0));
        chk("reset leaf_rd", 128'(bus.leaf_rd), 128'(0));
        chk("reset leaf_addr", 128'(bus.leaf_addr), 128'(0));
        chk("reset leaf_wr_data", 128'(bus.leaf_wr_data), 128'(0));
        chk("reset host_rd_data", 128'(bus.host_rd_data), 128'(0));
        chk("reset unmapped_err", 128'(unmapped_err), 128'(0));
        reset = 1'b0;
        mon_en = 1'b1;
        tick(2);

        access(1'b1, 1'b0, 1'b0, 32'h1000_0010, 32'hA5A5_0001, "wr leaf1");
        for (int i = 0; i < c_n; i++)
            chk("wr bcast addr", 128'(bus.leaf_addr[32*i +: 32]), 128'(32'h1000_0010));
        tick(2);

        access(1'b0, 1'b1, 1'b0, 32'h2000_0004, 32'h0, "rd overlap");
        tick(12);

        access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "b2b rd0");
        access(1'b0, 1'b1, 1'b0, 32'h1000_0200, 32'h0, "b2b rd1");
        access(1'b0, 1'b1, 1'b0, 32'h2000_0300, 32'h0, "b2b rd2");
        tick(6);

        access(1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h0, "rd unmapped");
        tick(5);
        access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, "err_clear");
        access(1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'h0BAD_BEEF, "clr vs set");
        tick(1);
        access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, "err_clear2");
        tick(2);

        access(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'hC0DE_0007, "wr+rd");
        tick(6);

        access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "rd before reset");
        tick(1);
        reset    = 1'b1;
        sb.delete();
        exp_hold = '0;
        exp_err  = 1'b0;
        #1;
        chk("midreset leaf_rd", 128'(bus.leaf_rd), 128'(0));
        chk("midreset leaf_wr", 128'(bus.leaf_wr), 128'(0));
        chk("midreset host_rd_data", 128'(bus.host_rd_data), 128'(0));
        chk("midreset unmapped_err", 128'(unmapped_err), 128'(0));
        tick(1);
        reset = 1'b0;
        tick(8);

        leaf_val[1] = 32'h7777_0011;
        access(1'b0, 1'b1, 1'b0, 32'h1ABC_0000, 32'h0, "rd after reset");
        tick(6);

        chk("scoreboard drained", 128'(sb.size()), 128'(0));
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
